// File: rtl/rsa_job_arbiter_pkg.sv
// Shared types for the RSA job arbiter: job/result payloads and arbiter FSM states.
// The core and all requesters use the same packed payload layout.
package rsa_job_arbiter_pkg;

    localparam int RSA_W = 16;

    typedef struct packed {
        logic [RSA_W-1:0] msg;
        logic [RSA_W-1:0] key;
        logic [RSA_W-1:0] modulus;
    } RSAModIn;

    typedef struct packed {
        logic [RSA_W-1:0] result;
    } RSAModOut;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } RSAArbState_t;

endpackage

// File: rtl/rsa_job_arbiter_if.sv
// Requester-side and core-side handshakes of the RSA job arbiter.
// master = arbiter, slave = requesters plus RSA core.
interface rsa_job_arbiter_if #(
    parameter int N_REQ = 4
);
    import rsa_job_arbiter_pkg::*;

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    RSAModIn [N_REQ-1:0] req_in;
    logic [N_REQ-1:0]    rsp_valid;
    logic [N_REQ-1:0]    rsp_ready;
    RSAModOut            rsp_out;
    logic                core_i_valid;
    logic                core_i_ready;
    RSAModIn             core_i_in;
    logic                core_o_valid;
    logic                core_o_ready;
    RSAModOut            core_o_out;

    modport master (
        input  req_valid, req_in, rsp_ready, core_i_ready, core_o_valid, core_o_out,
        output req_ready, rsp_valid, rsp_out, core_i_valid, core_i_in, core_o_ready
    );

    modport slave (
        output req_valid, req_in, rsp_ready, core_i_ready, core_o_valid, core_o_out,
        input  req_ready, rsp_valid, rsp_out, core_i_valid, core_i_in, core_o_ready
    );

endinterface

// File: rtl/rsa_job_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first requester after last_i (wrapping) wins.
// last_i itself has the lowest priority, so a held request is served within N_REQ picks.
module rsa_job_arbiter_rr_pick #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             found_o,
    output logic [IDX_W-1:0] grant_o
);

    always_comb begin
        int idx;
        found_o = 1'b0;
        grant_o = '0;
        idx     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_i) + k) % N_REQ;
            if (!found_o && req_i[idx[IDX_W-1:0]]) begin
                found_o = 1'b1;
                grant_o = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rsa_job_arbiter.sv
// Shares one RSA modexp core among N_REQ requesters, one job in flight, round-robin grant.
// Accept->core 1 cycle, core result->response 1 cycle; stalls hold job/result stable.
module rsa_job_arbiter
    import rsa_job_arbiter_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    rsa_job_arbiter_if.master bus,
    output logic              busy_o,
    output logic [IDX_W-1:0]  owner_o
);

    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    RSAArbState_t     state_q;
    RSAModIn          job_q;
    RSAModOut         res_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] last_q;
    logic             core_i_valid_q;
    logic             core_o_ready_q;
    logic             busy_q;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    rsa_job_arbiter_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i   (bus.req_valid),
        .last_i  (last_q),
        .found_o (pick_found),
        .grant_o (pick_idx)
    );

    // Only the grant and the response routing are decoded; everything else is a register.
    assign bus.req_ready    = (state_q == ARB_IDLE && pick_found) ? (ONE_HOT0 << pick_idx) : '0;
    assign bus.rsp_valid    = (state_q == ARB_RESP) ? (ONE_HOT0 << owner_q) : '0;
    assign bus.rsp_out      = res_q;
    assign bus.core_i_valid = core_i_valid_q;
    assign bus.core_i_in    = job_q;
    assign bus.core_o_ready = core_o_ready_q;
    assign busy_o           = busy_q;
    assign owner_o          = owner_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ARB_IDLE;
            job_q          <= '0;
            res_q          <= '0;
            owner_q        <= '0;
            last_q         <= IDX_W'(N_REQ - 1);
            core_i_valid_q <= 1'b0;
            core_o_ready_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (pick_found) begin
                        job_q          <= bus.req_in[pick_idx];
                        owner_q        <= pick_idx;
                        core_i_valid_q <= 1'b1;
                        busy_q         <= 1'b1;
                        state_q        <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (bus.core_i_ready) begin
                        core_i_valid_q <= 1'b0;
                        core_o_ready_q <= 1'b1;
                        state_q        <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (bus.core_o_valid) begin
                        res_q          <= bus.core_o_out;
                        core_o_ready_q <= 1'b0;
                        state_q        <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    // Winner drops to lowest priority for the next round.
                    if (bus.rsp_ready[owner_q]) begin
                        last_q  <= owner_q;
                        busy_q  <= 1'b0;
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Bench for rsa_job_arbiter: vector table, directed corner sequences and a random run
// against a job-level model (modexp results, distance-based round-robin rule).
module tb_rsa_job_arbiter;
    import rsa_job_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int IW = $clog2(N);

    typedef struct {
        logic [N-1:0]     mask;
        RSAModIn          job;
        int               exp_g;
        logic [RSA_W-1:0] exp_r;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            busy_o;
    logic [IW-1:0]   owner_o;

    always #5 clk = ~clk;

    rsa_job_arbiter_if #(.N_REQ(N)) bus ();

    rsa_job_arbiter #(.N_REQ(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy_o  (busy_o),
        .owner_o (owner_o)
    );

    int tests = 0;
    int fails = 0;

    // requester model
    bit      pend  [N];
    bit      autoq [N];
    RSAModIn pjob  [N];
    int      wcnt  [N];
    int      gen_left;
    // job model: 0 none, 1 awaiting core accept, 2 at core, 3 result held for owner
    int               ph;
    int               own_m;
    int               last_m;
    RSAModIn          cur_job;
    logic [RSA_W-1:0] cur_res;
    logic [RSA_W-1:0] last_rsp;
    int               n_acc;
    int               n_done;
    int               glog [$];
    // core stub
    bit               sb_busy;
    bit               sb_done;
    int               sb_cnt;
    logic [RSA_W-1:0] sb_res;
    int               lat_fix;
    // stimulus knobs
    bit rand_rr;
    bit rand_ci;
    bit hold_mode;
    int ci_block;
    int rr_block;
    int ci_cyc;
    int rr_cyc;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [RSA_W-1:0] modexp(input RSAModIn j);
        longint unsigned r, b, m;
        m = 64'(j.modulus);
        if (m == 0) return '0;
        r = 1 % m;
        b = 64'(j.msg) % m;
        for (int k = 0; k < RSA_W; k++) begin
            if (j.key[k]) r = (r * b) % m;
            b = (b * b) % m;
        end
        return RSA_W'(r);
    endfunction

    function automatic RSAModIn rand_job();
        RSAModIn j;
        j.msg     = RSA_W'($urandom_range(0, 999));
        j.key     = RSA_W'($urandom_range(0, 40));
        j.modulus = RSA_W'($urandom_range(1, 999));
        return j;
    endfunction

    function automatic RSAModIn mk(input int m, input int k, input int md);
        RSAModIn j;
        j.msg     = RSA_W'(m);
        j.key     = RSA_W'(k);
        j.modulus = RSA_W'(md);
        return j;
    endfunction

    task automatic clear_pend();
        for (int i = 0; i < N; i++) begin
            pend[i]  = 1'b0;
            autoq[i] = 1'b0;
            wcnt[i]  = 0;
        end
    endtask

    // One clock: drive at negedge, sample 1ns later, then advance the model by the
    // handshakes that will complete on the following posedge.
    task automatic step();
        logic [N-1:0] rv, rr, exp_rdy, exp_rsp;
        logic         ci;
        int           g, bd, d;
        @(negedge clk);
        if (gen_left > 0)
            for (int i = 0; i < N; i++)
                if (!pend[i] && gen_left > 0 && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    pjob[i] = rand_job();
                    gen_left--;
                end
        if (sb_busy && !sb_done) begin
            if (sb_cnt <= 1) sb_done = 1'b1;
            else sb_cnt--;
        end
        rv = {pend[3], pend[2], pend[1], pend[0]};
        rr = rand_rr ? N'($urandom) : '1;
        ci = !sb_busy && (!rand_ci || $urandom_range(0, 3) != 0);
        if (hold_mode && ph == 1) begin
            ci = (ci_block == 0) && !sb_busy;
            if (ci_block > 0) ci_block--;
        end
        if (hold_mode && ph == 3) begin
            rr[own_m[IW-1:0]] = (rr_block == 0);
            if (rr_block > 0) rr_block--;
        end
        bus.req_valid         = rv;
        bus.req_in            = {pjob[3], pjob[2], pjob[1], pjob[0]};
        bus.rsp_ready         = rr;
        bus.core_i_ready      = ci;
        bus.core_o_valid      = sb_done;
        bus.core_o_out.result = sb_res;
        #1;
        chk("busy", 64'(busy_o), 64'(ph != 0));
        chk("owner", 64'(owner_o), 64'(own_m));
        chk("core_i_valid", 64'(bus.core_i_valid), 64'(ph == 1));
        if (ph == 1) begin
            chk("core_i_in", 64'(bus.core_i_in), 64'(cur_job));
            ci_cyc++;
        end
        chk("core_o_ready", 64'(bus.core_o_ready), 64'(ph == 2));
        exp_rsp = (ph == 3) ? (N'(1) << own_m) : '0;
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rsp));
        if (ph == 3) begin
            chk("rsp_out", 64'(bus.rsp_out.result), 64'(cur_res));
            rr_cyc++;
        end
        // winner = valid requester with the smallest distance past the last owner
        g  = -1;
        bd = N;
        if (ph == 0)
            for (int i = 0; i < N; i++) begin
                d = (i - last_m - 1 + 2 * N) % N;
                if (pend[i] && d < bd) begin
                    bd = d;
                    g  = i;
                end
            end
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));

        if (g >= 0) begin
            chk("no_starve", 64'(wcnt[g] < N), 64'd1);
            for (int i = 0; i < N; i++)
                if (pend[i] && i != g) wcnt[i]++;
            wcnt[g] = 0;
            ph      = 1;
            own_m   = g;
            cur_job = pjob[g];
            cur_res = modexp(pjob[g]);
            glog.push_back(g);
            n_acc++;
            if (autoq[g]) pjob[g] = rand_job();
            else pend[g] = 1'b0;
        end else if (ph == 1 && ci) begin
            sb_busy = 1'b1;
            sb_done = 1'b0;
            sb_cnt  = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 20));
            sb_res  = modexp(bus.core_i_in);
            ph      = 2;
        end else if (ph == 2 && sb_done) begin
            sb_busy = 1'b0;
            sb_done = 1'b0;
            ph      = 3;
        end else if (ph == 3 && rr[own_m[IW-1:0]]) begin
            last_rsp = bus.rsp_out.result;
            last_m   = own_m;
            ph       = 0;
            n_done++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst              = 1'b1;
        bus.req_valid    = '0;
        bus.req_in       = '0;
        bus.rsp_ready    = '0;
        bus.core_i_ready = 1'b0;
        bus.core_o_valid = 1'b0;
        bus.core_o_out   = '0;
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_core_i_valid", 64'(bus.core_i_valid), 64'd0);
        chk("rst_core_o_ready", 64'(bus.core_o_ready), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_owner", 64'(owner_o), 64'd0);
        chk("rst_rsp_out", 64'(bus.rsp_out), 64'd0);
        chk("rst_core_i_in", 64'(bus.core_i_in), 64'd0);
        ph      = 0;
        own_m   = 0;
        last_m  = N - 1;
        sb_busy = 1'b0;
        sb_done = 1'b0;
        sb_res  = '0;
        clear_pend();
        glog.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_jobs(input int n, input int budget);
        int target;
        int cyc;
        target = n_done + n;
        cyc    = 0;
        while (n_done < target && cyc < budget) begin
            step();
            cyc++;
        end
        chk("jobs_done", 64'(n_done), 64'(target));
    endtask

    initial begin
        int cyc;
        int npend;
        rst       = 1'b1;
        gen_left  = 0;
        n_acc     = 0;
        n_done    = 0;
        lat_fix   = 0;
        rand_rr   = 1'b0;
        rand_ci   = 1'b0;
        hold_mode = 1'b0;
        ci_block  = 0;
        rr_block  = 0;
        ci_cyc    = 0;
        rr_cyc    = 0;
        last_rsp  = '0;
        cur_res   = '0;
        cur_job   = '0;
        for (int i = 0; i < N; i++) pjob[i] = '0;
        do_reset();

        // grant order follows from rotating priority starting after requester 3
        tbl[0] = '{4'b0001, mk(2, 5, 13),    0, 16'd6};
        tbl[1] = '{4'b1111, mk(3, 4, 7),     1, 16'd4};
        tbl[2] = '{4'b1111, mk(3, 4, 7),     2, 16'd4};
        tbl[3] = '{4'b1111, mk(3, 4, 7),     3, 16'd4};
        tbl[4] = '{4'b1111, mk(3, 4, 7),     0, 16'd4};
        tbl[5] = '{4'b0100, mk(2, 10, 1000), 2, 16'd24};
        tbl[6] = '{4'b0110, mk(5, 3, 100),   1, 16'd25};
        tbl[7] = '{4'b1001, mk(7, 2, 10),    3, 16'd9};
        tbl[8] = '{4'b1010, mk(3, 3, 5),     1, 16'd2};
        tbl[9] = '{4'b0011, mk(0, 5, 7),     0, 16'd0};
        rand_ci = 1'b1;
        for (int v = 0; v < 10; v++) begin
            clear_pend();
            glog.delete();
            for (int i = 0; i < N; i++)
                if (tbl[v].mask[i[IW-1:0]]) begin
                    pend[i] = 1'b1;
                    pjob[i] = tbl[v].job;
                end
            run_jobs(1, 200);
            chk($sformatf("tbl%0d_grant", v), 64'(glog.size() > 0 ? glog[0] : -1), 64'(tbl[v].exp_g));
            chk($sformatf("tbl%0d_result", v), 64'(last_rsp), 64'(tbl[v].exp_r));
        end
        clear_pend();
        rand_ci = 1'b0;

        // all four held valid from reset: one lap 0,1,2,3
        do_reset();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1;
            pjob[i] = mk(3, 4, 7);
        end
        run_jobs(4, 400);
        for (int i = 0; i < N; i++)
            chk($sformatf("lap_grant%0d", i), 64'(glog.size() > i ? glog[i] : -1), 64'(i));
        clear_pend();

        // requester 2 continuous, requester 1 joins after 2's first grant
        do_reset();
        pend[2]  = 1'b1;
        autoq[2] = 1'b1;
        pjob[2]  = rand_job();
        cyc      = 0;
        while (glog.size() < 1 && cyc < 50) begin
            step();
            cyc++;
        end
        pend[1]  = 1'b1;
        autoq[1] = 1'b1;
        pjob[1]  = rand_job();
        run_jobs(4, 400);
        chk("alt0", 64'(glog.size() > 0 ? glog[0] : -1), 64'd2);
        chk("alt1", 64'(glog.size() > 1 ? glog[1] : -1), 64'd1);
        chk("alt2", 64'(glog.size() > 2 ? glog[2] : -1), 64'd2);
        chk("alt3", 64'(glog.size() > 3 ? glog[3] : -1), 64'd1);
        clear_pend();

        // back-pressure on both sides with others waiting and non-owner rsp_ready toggling
        do_reset();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1;
            pjob[i] = mk(2 + i, 7, 101);
        end
        hold_mode = 1'b1;
        rand_rr   = 1'b1;
        ci_block  = 10;
        rr_block  = 7;
        ci_cyc    = 0;
        rr_cyc    = 0;
        run_jobs(1, 200);
        chk("bp_issue_cycles", 64'(ci_cyc), 64'd11);
        chk("bp_resp_cycles", 64'(rr_cyc), 64'd8);
        chk("bp_owner", 64'(glog.size() > 0 ? glog[0] : -1), 64'd0);
        hold_mode = 1'b0;
        rand_rr   = 1'b0;
        clear_pend();

        // reset while the core holds the job
        do_reset();
        lat_fix = 20;
        pend[1] = 1'b1;
        pjob[1] = mk(9, 9, 97);
        cyc     = 0;
        while (ph != 2 && cyc < 50) begin
            step();
            cyc++;
        end
        step();
        step();
        chk("wait_core_o_ready", 64'(bus.core_o_ready), 64'd1);
        do_reset();
        lat_fix = 0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1;
            pjob[i] = rand_job();
        end
        run_jobs(1, 200);
        chk("post_rst_grant", 64'(glog.size() > 0 ? glog[0] : -1), 64'd0);
        clear_pend();

        // random traffic
        do_reset();
        rand_rr  = 1'b1;
        rand_ci  = 1'b1;
        n_acc    = 0;
        n_done   = 0;
        gen_left = 2000;
        run_jobs(2000, 80000);
        npend = 0;
        for (int i = 0; i < N; i++) npend += int'(pend[i]);
        chk("rand_all_generated", 64'(gen_left), 64'd0);
        chk("rand_acc_eq_done", 64'(n_acc), 64'(n_done));
        chk("rand_none_pending", 64'(npend), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
